// File: rtl/rtcsched_pkg.sv
// Shared types for the rtctimer scheduler: FSM states, timer status bit positions, BCD check.
package rtcsched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_STOP,
    S_CLEAR,
    S_RELEASE
  } state_t;

  localparam int TMR_RUN_BIT   = 24;
  localparam int TMR_ALARM_BIT = 25;

  // HH:MM:SS packed BCD; hour tens is not range-checked.
  function automatic logic bcd_ok(input logic [23:0] t);
    return !((t[19:16] > 4'd9) || (t[15:12] > 4'd5) || (t[11:8] > 4'd9) ||
             (t[7:4]   > 4'd5) || (t[3:0]   > 4'd9));
  endfunction

endpackage

// File: rtl/rtctimer_sched_if.sv
// Client request/response bus and rtctimer write/status bus of the scheduler.
interface rtctimer_sched_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      i_req;
  logic [24*NREQ-1:0]   i_req_time;
  logic [NREQ-1:0]      i_cancel;
  logic [NREQ-1:0]      o_grant;
  logic [NREQ-1:0]      o_done;
  logic [NREQ-1:0]      o_cancelled;
  logic [NREQ-1:0]      o_err;
  logic                 o_busy;
  logic                 o_tmr_wr;
  logic [24:0]          o_tmr_data;
  logic [2:0]           o_tmr_valid;
  logic                 o_tmr_zero;
  logic [31:0]          i_tmr_data;
  logic                 i_tmr_int;

  modport master (
    input  i_req, i_req_time, i_cancel, i_tmr_data, i_tmr_int,
    output o_grant, o_done, o_cancelled, o_err, o_busy,
           o_tmr_wr, o_tmr_data, o_tmr_valid, o_tmr_zero
  );

  modport slave (
    output i_req, i_req_time, i_cancel, i_tmr_data, i_tmr_int,
    input  o_grant, o_done, o_cancelled, o_err, o_busy,
           o_tmr_wr, o_tmr_data, o_tmr_valid, o_tmr_zero
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins, one-hot grant plus index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o
);

  always_comb begin
    int   k;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k[$clog2(N)-1:0];
      end
    end
  end

endmodule

// File: rtl/rtctimer_sched.sv
// Shares one rtctimer among NREQ clients: round-robin grant, load/start, watch, clear, release.
// Defining RTCSCHED_CANCEL_EN builds the STOP path so the owner's i_cancel is honoured.
module rtctimer_sched
  import rtcsched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LGWDOG = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  rtctimer_sched_if.master  bus
);

  localparam int IW = $clog2(NREQ);

  state_t             state_q;
  logic [IW-1:0]      ptr_q, owner_q;
  logic [23:0]        time_q;
  logic [LGWDOG-1:0]  wdog_q;
  logic [NREQ-1:0]    grant_q, done_q, err_q;
  logic               wr_q, wzero_q;
  logic [24:0]        wdat_q;
  logic [2:0]         wvld_q;
  logic [NREQ-1:0]    arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               running;
  logic               unused_status;
`ifdef RTCSCHED_CANCEL_EN
  logic [NREQ-1:0]    canc_q;
  logic               canc_flag_q;
  logic               cancel_own;
  assign cancel_own = |(bus.i_cancel & grant_q);
`endif

  assign running = bus.i_tmr_data[TMR_RUN_BIT];

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      time_q  <= '0;
      wdog_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      wvld_q  <= '0;
      wzero_q <= 1'b0;
`ifdef RTCSCHED_CANCEL_EN
      canc_q      <= '0;
      canc_flag_q <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= '0;
      wr_q   <= 1'b0;
`ifdef RTCSCHED_CANCEL_EN
      canc_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|bus.i_req) begin
            grant_q <= arb_grant;
            owner_q <= arb_idx;
            time_q  <= bus.i_req_time[24*arb_idx +: 24];
            state_q <= S_LOAD;
`ifdef RTCSCHED_CANCEL_EN
            canc_flag_q <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (!bcd_ok(time_q)) begin
            err_q   <= grant_q;
            state_q <= S_RELEASE;
          end else if (time_q == 24'd0) begin
            done_q  <= grant_q;
            state_q <= S_RELEASE;
          end else begin
            wr_q    <= 1'b1;
            wdat_q  <= {1'b1, time_q};
            wvld_q  <= 3'b111;
            wzero_q <= 1'b0;
            wdog_q  <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
`ifdef RTCSCHED_CANCEL_EN
          if (cancel_own) begin
            wr_q        <= 1'b1;
            wdat_q      <= {1'b0, time_q};
            wvld_q      <= 3'b000;
            wzero_q     <= 1'b0;
            canc_flag_q <= 1'b1;
            state_q     <= S_STOP;
          end else
`endif
          if (running) begin
            state_q <= S_RUN;
          end else if (&wdog_q) begin
            err_q   <= grant_q;
            state_q <= S_CLEAR;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_RUN: begin
          // Interrupt outranks a same-cycle cancel.
          if (bus.i_tmr_int || !running) begin
            done_q  <= grant_q;
            state_q <= S_CLEAR;
          end
`ifdef RTCSCHED_CANCEL_EN
          else if (cancel_own) begin
            wr_q        <= 1'b1;
            wdat_q      <= {1'b0, time_q};
            wvld_q      <= 3'b000;
            wzero_q     <= 1'b0;
            canc_flag_q <= 1'b1;
            state_q     <= S_STOP;
          end
        end
        S_STOP: begin
          state_q <= S_CLEAR;
`endif
        end
        S_CLEAR: begin
          // Zero-flagged write with no valid bytes drops the alarm but keeps the count.
          if (!running) begin
            wr_q    <= 1'b1;
            wdat_q  <= '0;
            wvld_q  <= 3'b000;
            wzero_q <= 1'b1;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          grant_q <= '0;
          ptr_q   <= (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
          state_q <= S_IDLE;
`ifdef RTCSCHED_CANCEL_EN
          if (canc_flag_q) canc_q <= grant_q;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_tmr_wr    = wr_q;
  assign bus.o_tmr_data  = wdat_q;
  assign bus.o_tmr_valid = wvld_q;
  assign bus.o_tmr_zero  = wzero_q;
`ifdef RTCSCHED_CANCEL_EN
  assign bus.o_cancelled = canc_q;
  assign unused_status   = ^{bus.i_tmr_data[31:TMR_ALARM_BIT], bus.i_tmr_data[23:0]};
`else
  assign bus.o_cancelled = '0;
  assign unused_status   = ^{bus.i_tmr_data[31:TMR_ALARM_BIT], bus.i_tmr_data[23:0], bus.i_cancel};
`endif

endmodule

// File: tb/tb_rtctimer_sched.sv
// Bench for rtctimer_sched: behavioural rtctimer, event scoreboard, vector table and corner sequences.
module tb_rtctimer_sched;
  localparam int NREQ = 4;

  typedef enum logic [1:0] {K_WR, K_DONE, K_ERR, K_CANC} kind_t;
  typedef struct packed {
    kind_t            kind;
    logic [NREQ-1:0]  who;
    logic [24:0]      dat;
    logic [2:0]       vld;
    logic             zero;
  } ev_t;
  typedef enum logic [1:0] {OC_RUN, OC_ZERO, OC_BAD} outc_t;
  typedef struct {
    int          client;
    logic [23:0] t;
    outc_t       oc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtctimer_sched_if #(.NREQ(NREQ)) bus ();
  rtctimer_sched #(.NREQ(NREQ), .LGWDOG(3)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];

  // Behavioural timer: binary countdown is enough for the small test values.
  logic        m_run, m_alarm, m_int, stuck;
  logic [23:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_alarm <= 1'b0; m_int <= 1'b0; m_cnt <= '0;
    end else begin
      m_int <= 1'b0;
      if (bus.o_tmr_wr) begin
        if (bus.o_tmr_data[24]) begin
          if (!stuck) begin m_cnt <= bus.o_tmr_data[23:0]; m_run <= 1'b1; end
        end else if (bus.o_tmr_zero) m_alarm <= 1'b0;
        else m_run <= 1'b0;
      end else if (m_run) begin
        if (m_cnt <= 24'd1) begin
          m_cnt <= '0; m_run <= 1'b0; m_alarm <= 1'b1; m_int <= 1'b1;
        end else m_cnt <= m_cnt - 24'd1;
      end
    end
  end
  assign bus.i_tmr_data = {6'b0, m_alarm, m_run, m_cnt};
  assign bus.i_tmr_int  = m_int;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input kind_t k, input logic [NREQ-1:0] w,
                             input logic [24:0] d, input logic [2:0] v, input logic z);
    ev_t e;
    e.kind = k; e.who = w; e.dat = d; e.vld = v; e.zero = z;
    return e;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int c);
    return NREQ'(1) << c;
  endfunction

  task automatic sb_check(input ev_t got);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got %h, expected no event", got);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_bad++;
        $display("FAIL sb_event: got %h, expected %h", got, e);
      end
    end
  endtask

  // Monitor: every timer write and every client pulse must match the next expected event.
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) prev_wr = 1'b0;
    else begin
      if (bus.o_tmr_wr) begin
        cmp("wr_back_to_back", 64'(prev_wr), 64'd0);
        sb_check(mk(K_WR, '0, bus.o_tmr_data, bus.o_tmr_valid, bus.o_tmr_zero));
      end
      if (|{bus.o_done, bus.o_err, bus.o_cancelled}) begin
        cmp("pulse_exclusive", 64'($countones({|bus.o_done, |bus.o_err, |bus.o_cancelled})), 64'd1);
        if (|bus.o_done)     sb_check(mk(K_DONE, bus.o_done, '0, '0, 1'b0));
        else if (|bus.o_err) sb_check(mk(K_ERR, bus.o_err, '0, '0, 1'b0));
        else                 sb_check(mk(K_CANC, bus.o_cancelled, '0, '0, 1'b0));
      end
      prev_wr = bus.o_tmr_wr;
    end
  end

  task automatic push_run(input int c, input logic [23:0] t);
    exp_q.push_back(mk(K_WR, '0, {1'b1, t}, 3'b111, 1'b0));
    exp_q.push_back(mk(K_DONE, oh(c), '0, '0, 1'b0));
    exp_q.push_back(mk(K_WR, '0, 25'd0, 3'b000, 1'b1));
  endtask

  task automatic drive_req(input int c, input logic [23:0] t);
    bus.i_req_time[24*c +: 24] = t;
    bus.i_req[c] = 1'b1;
  endtask

  task automatic wait_pulse(input int c);
    logic [NREQ-1:0] pv;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pv = bus.o_done | bus.o_err | bus.o_cancelled;
      if (pv[c]) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_pulse: client %0d got no completion, expected one within 3000 cycles", c);
  endtask

  task automatic finish_txn();
    int i;
    for (i = 0; i < 50 && bus.o_busy; i++) @(negedge clk);
    @(negedge clk);
    cmp("busy_after_release", 64'(bus.o_busy), 64'd0);
    cmp("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic serve(input int c, input logic [23:0] t, input outc_t oc);
    case (oc)
      OC_RUN:  push_run(c, t);
      OC_ZERO: exp_q.push_back(mk(K_DONE, oh(c), '0, '0, 1'b0));
      default: exp_q.push_back(mk(K_ERR, oh(c), '0, '0, 1'b0));
    endcase
    drive_req(c, t);
    wait_pulse(c);
    bus.i_req[c] = 1'b0;
    finish_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1);
  end

  vec_t vecs[8];
  int   cnt;

  initial begin
    vecs[0] = '{0, 24'h000005, OC_RUN};
    vecs[1] = '{3, 24'h000000, OC_ZERO};
    vecs[2] = '{1, 24'h00006A, OC_BAD};
    vecs[3] = '{2, 24'h000060, OC_BAD};
    vecs[4] = '{0, 24'h007000, OC_BAD};
    vecs[5] = '{3, 24'h0A0000, OC_BAD};
    vecs[6] = '{1, 24'h000110, OC_RUN};
    vecs[7] = '{2, 24'h000059, OC_RUN};

    stuck = 1'b0;
    bus.i_req = '0; bus.i_req_time = '0; bus.i_cancel = '0;
    repeat (3) @(negedge clk);
    cmp("reset_outputs", 64'({bus.o_grant, bus.o_done, bus.o_err, bus.o_cancelled, bus.o_busy,
                              bus.o_tmr_wr, bus.o_tmr_data, bus.o_tmr_valid, bus.o_tmr_zero}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clients 0 and 1 together from pointer 0: 0 first, then 1.
    push_run(0, 24'h000002);
    push_run(1, 24'h000002);
    drive_req(0, 24'h000002);
    drive_req(1, 24'h000002);
    @(negedge clk);
    cmp("rr_first_grant", 64'(bus.o_grant), 64'(oh(0)));
    wait_pulse(0); bus.i_req[0] = 1'b0;
    wait_pulse(1); bus.i_req[1] = 1'b0;
    finish_txn();

    // Pointer now 2: 0,1,2 request zero time -> served 2, 0, 1.
    exp_q.push_back(mk(K_DONE, oh(2), '0, '0, 1'b0));
    exp_q.push_back(mk(K_DONE, oh(0), '0, '0, 1'b0));
    exp_q.push_back(mk(K_DONE, oh(1), '0, '0, 1'b0));
    drive_req(0, 24'h0); drive_req(1, 24'h0); drive_req(2, 24'h0);
    @(negedge clk);
    cmp("ptr_after_rr", 64'(bus.o_grant), 64'(oh(2)));
    wait_pulse(2); bus.i_req[2] = 1'b0;
    wait_pulse(0); bus.i_req[0] = 1'b0;
    wait_pulse(1); bus.i_req[1] = 1'b0;
    finish_txn();

    // Client 2, 3 seconds: grant at N+1, write at N+2, done the cycle after the interrupt.
    push_run(2, 24'h000003);
    drive_req(2, 24'h000003);
    @(negedge clk);
    cmp("grant_n1", 64'(bus.o_grant), 64'(oh(2)));
    @(negedge clk);
    cmp("load_wr_n2", 64'({bus.o_tmr_wr, bus.o_tmr_data}), 64'({1'b1, 25'h1000003}));
    for (cnt = 0; cnt < 100 && !bus.i_tmr_int; cnt++) @(negedge clk);
    cmp("tmr_int_seen", 64'(bus.i_tmr_int), 64'd1);
    @(negedge clk);
    cmp("done_after_int", 64'(bus.o_done), 64'(oh(2)));
    bus.i_req[2] = 1'b0;
    finish_txn();

    for (int i = 0; i < 8; i++) serve(vecs[i].client, vecs[i].t, vecs[i].oc);

    // Owner cancels five cycles into RUN.
    exp_q.push_back(mk(K_WR, '0, {1'b1, 24'h000020}, 3'b111, 1'b0));
`ifdef RTCSCHED_CANCEL_EN
    exp_q.push_back(mk(K_WR, '0, {1'b0, 24'h000020}, 3'b000, 1'b0));
    exp_q.push_back(mk(K_WR, '0, 25'd0, 3'b000, 1'b1));
    exp_q.push_back(mk(K_CANC, oh(3), '0, '0, 1'b0));
`else
    exp_q.push_back(mk(K_DONE, oh(3), '0, '0, 1'b0));
    exp_q.push_back(mk(K_WR, '0, 25'd0, 3'b000, 1'b1));
`endif
    drive_req(3, 24'h000020);
    for (cnt = 0; cnt < 20 && !m_run; cnt++) @(negedge clk);
    repeat (6) @(negedge clk);
    bus.i_cancel[3] = 1'b1;
    @(negedge clk);
    bus.i_cancel[3] = 1'b0;
`ifdef RTCSCHED_CANCEL_EN
    cmp("stop_wr_m1", 64'({bus.o_tmr_wr, bus.o_tmr_data[24]}), 64'({1'b1, 1'b0}));
`else
    cmp("cancel_ignored", 64'(bus.o_tmr_wr), 64'd0);
`endif
    wait_pulse(3);
    bus.i_req[3] = 1'b0;
    finish_txn();

    // Timer never starts: error after 8 START cycles, then CLEAR and RELEASE.
    stuck = 1'b1;
    exp_q.push_back(mk(K_WR, '0, {1'b1, 24'h000004}, 3'b111, 1'b0));
    exp_q.push_back(mk(K_ERR, oh(1), '0, '0, 1'b0));
    exp_q.push_back(mk(K_WR, '0, 25'd0, 3'b000, 1'b1));
    drive_req(1, 24'h000004);
    for (cnt = 0; cnt < 10 && !bus.o_tmr_wr; cnt++) @(negedge clk);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.o_err[1] && cnt < 30);
    cmp("wdog_cycles", 64'(cnt), 64'd8);
    bus.i_req[1] = 1'b0;
    finish_txn();
    stuck = 1'b0;

    // Reset in RUN: everything drops at once, next request is served normally.
    exp_q.push_back(mk(K_WR, '0, {1'b1, 24'h000040}, 3'b111, 1'b0));
    drive_req(0, 24'h000040);
    for (cnt = 0; cnt < 20 && !m_run; cnt++) @(negedge clk);
    repeat (4) @(negedge clk);
    cmp("busy_before_reset", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    cmp("reset_mid_run", 64'({bus.o_grant, bus.o_done, bus.o_err, bus.o_cancelled, bus.o_busy,
                              bus.o_tmr_wr, bus.o_tmr_data, bus.o_tmr_valid, bus.o_tmr_zero}), 64'd0);
    cmp("sb_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    bus.i_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    serve(0, 24'h000003, OC_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtctimer_sched.md
# rtctimer_sched

Round-robin scheduler that shares one BCD countdown timer (`rtctimer`) among `NREQ` requesters. It arbitrates requests, loads and starts the timer through its write port, and watches the timer's status word and interrupt. It reports completion, cancellation or error to the owning requester. It sits between the per-client control registers and the single `rtctimer` instance in the RTC core.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LGWDOG`, 3: log2 of the start-watchdog limit in cycles.
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_req`  in  NREQ  request per client, held high until `o_done`/`o_err` for that client.
- `i_req_time`  in  24*NREQ  BCD HH:MM:SS per client, slice k = [24k+23:24k]; sampled at grant.
- `i_cancel`  in  NREQ  cancel request, honoured only for the current owner.
- `o_grant`  out  NREQ  one-hot owner, 0 when idle.
- `o_done`  out  NREQ  1-cycle pulse: countdown expired, or zero time.
- `o_cancelled`  out  NREQ  1-cycle pulse: owner's countdown stopped by cancel.
- `o_err`  out  NREQ  1-cycle pulse: illegal BCD, or start watchdog expired.
- `o_busy`  out  1  state != IDLE.
- `o_tmr_wr`  out  1  timer write strobe.
- `o_tmr_data`  out  25  bit24 = run, [23:0] = BCD value.
- `o_tmr_valid`  out  3  byte-valid field for the timer.
- `o_tmr_zero`  out  1  high iff `o_tmr_data[23:0]==0`.
- `i_tmr_data`  in  32  timer status: bit25 alarm, bit24 running, [23:0] count.
- `i_tmr_int`  in  1  timer expiry interrupt.

## Operation
- States: IDLE, LOAD, START, RUN, STOP, CLEAR, RELEASE.
- Reset: state IDLE; all outputs 0; RR pointer at client 0.
- IDLE:
  - Any `i_req` picks a winner by round-robin from the pointer (pointer = last owner + 1).
  - Sets `o_grant`, latches the owner index and `i_req_time`, goes to LOAD.
- LOAD:
  - Checks the latched time: any digit illegal (sec/min units >9, tens >5, hour units >9) → `o_err`, go to RELEASE.
  - Zero time → `o_done`, go to RELEASE; the timer is not written.
  - Otherwise: one-cycle `o_tmr_wr` with data {1'b1, time}, valid 3'b111, zero 0; go to START.
- START:
  - Waits for `i_tmr_data[24]`, then goes to RUN.
  - A watchdog counts START cycles. If it reaches 2^LGWDOG first → `o_err`, go to CLEAR.
- RUN:
  - `i_tmr_int` → `o_done`, go to CLEAR.
  - `i_tmr_data[24]` falls without the interrupt → `o_done`, go to CLEAR.
- STOP (cancel only): one write with data bit24=0, valid 0, zero 0; go to CLEAR.
- CLEAR:
  - Waits until `i_tmr_data[24]==0`.
  - Then issues one write with data 0, valid 0, zero 1; this clears the alarm and leaves the count intact.
  - Go to RELEASE.
- RELEASE: clear `o_grant`, advance the pointer, go to IDLE. A released client must drop `i_req` to avoid an immediate re-grant.
- Requests from non-owners are ignored while busy, with no queueing. `i_cancel` from non-owners is ignored.
- Simultaneous `i_tmr_int` and owner `i_cancel` in RUN: interrupt wins, `o_done` only.
- Reset mid-operation: the FSM returns to IDLE with no pulses. The timer is reset by the same reset net.

## Timing
- Request in IDLE at cycle N → `o_grant` at N+1.
- LOAD write is registered; `o_tmr_wr` is high at N+2.
- `o_done`/`o_err`/`o_cancelled` rise the cycle after the causing event and are never simultaneous.
- `o_tmr_wr` is never high on two consecutive cycles.
- At most one of `o_done`, `o_cancelled`, `o_err` fires per grant.
- Cancel: `i_cancel` seen at cycle M in RUN → STOP write at M+1.

## Configuration
- `RTCSCHED_CANCEL_EN` defined: the STOP state exists and `i_cancel` is honoured in START and RUN.
- Undefined: `i_cancel` is ignored, `o_cancelled` is tied 0, and STOP is not built.

## Structure
- Shared package `rtcsched_pkg`:
  - state enum;
  - the status bit positions (`TMR_RUN_BIT=24`, `TMR_ALARM_BIT=25`);
  - the BCD legality function.
- One sub-module, `rr_arbiter` (NREQ-wide, pointer-based, one-hot grant), instantiated once.

## Test plan
- Client 2 requests 24'h000003; timer model runs → grant[2] at N+1, write data 25'h1000003 at N+2, `o_done[2]` pulse the cycle after the model's `i_tmr_int`, then a CLEAR write with zero=1.
- Clients 0 and 1 request together, pointer=0 → client 0 served first, then client 1; after both complete, the pointer is at 2.
- Client 3 requests 24'h000000 → `o_done[3]` and no `o_tmr_wr`. Client 1 requests 24'h00006A → `o_err[1]` and no write.
- Cancel enabled: owner asserts `i_cancel` 5 cycles into RUN → STOP write (bit24=0), then CLEAR write, then `o_cancelled`. Built without the macro → the countdown completes with `o_done`.
- Timer model never sets running → `o_err` after 8 START cycles, then CLEAR and RELEASE.
- `i_reset_n` asserted during RUN → all outputs 0 immediately, state IDLE, next request served normally.
